// File: rtl/linear_proj_out_collector_pkg.sv
// Shared types and width helpers for the linear-projection output collector.
package linear_proj_out_collector_pkg;

  localparam int unsigned DEF_WIDTH      = 16;
  localparam int unsigned DEF_BLOCK_SIZE = 2;
  localparam int unsigned DEF_COL_Y      = 2;
  localparam int unsigned DEF_MAX_ROWS   = 16;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_FILLING = 2'd1,
    S_FULL    = 2'd2
  } slot_state_e;

  function automatic int unsigned blk_bits(input int unsigned width, input int unsigned bs);
    return bs * bs * width;
  endfunction

  function automatic int unsigned row_bits(input int unsigned width, input int unsigned bs,
                                           input int unsigned col_y);
    return col_y * bs * bs * width;
  endfunction

endpackage

// File: rtl/linear_proj_out_collector_row_slot.sv
// One row buffer slot: column storage, per-column write decode and slot state.
// Exposes its next-state view so the parent can register outputs with no extra latency.
module linear_proj_out_collector_row_slot
  import linear_proj_out_collector_pkg::*;
#(
  parameter int unsigned BLK_W = 64,
  parameter int unsigned COL_Y = 2,
  parameter int unsigned IDX_W = 5,
  localparam int unsigned COL_W = $clog2(COL_Y),
  localparam int unsigned ROW_W = COL_Y * BLK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              clear,
  input  logic [COL_W-1:0]  col,
  input  logic [BLK_W-1:0]  blk,
  input  logic [IDX_W-1:0]  row_idx,
  output slot_state_e       state,
  output slot_state_e       state_nxt_c,
  output logic [ROW_W-1:0]  row_nxt_c,
  output logic [IDX_W-1:0]  idx_nxt_c
);

  slot_state_e        state_q;
  logic [ROW_W-1:0]   row_q;
  logic [IDX_W-1:0]   idx_q;
  logic               last;

  assign state = state_q;
  assign last  = (col == COL_W'(COL_Y - 1));

  // Writes are only honoured while the slot still has room.
  always_comb begin
    state_nxt_c = state_q;
    row_nxt_c   = row_q;
    idx_nxt_c   = idx_q;
    if (clear) begin
      state_nxt_c = S_EMPTY;
    end else if (wr_en && (state_q != S_FULL)) begin
      for (int c = 0; c < int'(COL_Y); c++) begin
        if (col == COL_W'(c)) row_nxt_c[c*BLK_W +: BLK_W] = blk;
      end
      idx_nxt_c   = row_idx;
      state_nxt_c = last ? S_FULL : S_FILLING;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      row_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_nxt_c;
      row_q   <= row_nxt_c;
      idx_q   <= idx_nxt_c;
    end
  end

endmodule

// File: rtl/linear_proj_out_collector.sv
// Assembles COL_Y result blocks into rows, double-buffered, with valid/ready output.
// Define LINEAR_PROJ_OUT_OVERFLOW_EN to expose the sticky `overflow` drop flag.
module linear_proj_out_collector
  import linear_proj_out_collector_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int unsigned COL_Y      = DEF_COL_Y,
  parameter int unsigned MAX_ROWS   = DEF_MAX_ROWS,
  localparam int unsigned BLK_W = blk_bits(WIDTH, BLOCK_SIZE),
  localparam int unsigned ROW_W = row_bits(WIDTH, BLOCK_SIZE, COL_Y),
  localparam int unsigned IDX_W = $clog2(MAX_ROWS + 1),
  localparam int unsigned COL_W = $clog2(COL_Y)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BLK_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_data,
  output logic [IDX_W-1:0]  out_row_idx,
  output logic              busy,
  output logic              done
`ifdef LINEAR_PROJ_OUT_OVERFLOW_EN
  ,
  output logic              overflow
`endif
);

  slot_state_e        state     [2];
  slot_state_e        state_nxt [2];
  logic [ROW_W-1:0]   row_nxt   [2];
  logic [IDX_W-1:0]   idx_nxt   [2];

  logic               wr_slot, wr_slot_d;
  logic               rd_slot, rd_slot_d;
  logic [COL_W-1:0]   col_cnt, col_cnt_d;
  logic [IDX_W-1:0]   row_cnt, row_cnt_d;
  logic [IDX_W-1:0]   acc_cnt, acc_cnt_d;
  logic               done_d;
  logic               out_valid_d;
  logic [ROW_W-1:0]   out_data_d;
  logic [IDX_W-1:0]   out_row_idx_d;
  logic               busy_d;
  logic               active, wr_full, take, accept, last;

  assign active  = in_valid && !done;
  assign wr_full = (state[wr_slot] == S_FULL);
  assign take    = active && !wr_full;
  assign accept  = out_valid && out_ready;
  assign last    = (col_cnt == COL_W'(COL_Y - 1));

  for (genvar s = 0; s < 2; s++) begin : g_slot
    linear_proj_out_collector_row_slot #(
      .BLK_W (BLK_W),
      .COL_Y (COL_Y),
      .IDX_W (IDX_W)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (take && (wr_slot == 1'(s))),
      .clear       (accept && (rd_slot == 1'(s))),
      .col         (col_cnt),
      .blk         (in_data),
      .row_idx     (row_cnt),
      .state       (state[s]),
      .state_nxt_c (state_nxt[s]),
      .row_nxt_c   (row_nxt[s]),
      .idx_nxt_c   (idx_nxt[s])
    );
  end

  // Pointer/counter update; outputs are registered from the slots' next-state view.
  always_comb begin
    wr_slot_d = wr_slot;
    rd_slot_d = rd_slot;
    col_cnt_d = col_cnt;
    row_cnt_d = row_cnt;
    acc_cnt_d = acc_cnt;
    done_d    = done;
    if (take) begin
      if (last) begin
        col_cnt_d = '0;
        wr_slot_d = ~wr_slot;
        row_cnt_d = row_cnt + IDX_W'(1);
      end else begin
        col_cnt_d = col_cnt + COL_W'(1);
      end
    end
    if (accept) begin
      rd_slot_d = ~rd_slot;
      acc_cnt_d = acc_cnt + IDX_W'(1);
      if (acc_cnt == IDX_W'(MAX_ROWS - 1)) done_d = 1'b1;
    end
    out_valid_d   = !done_d && (state_nxt[rd_slot_d] == S_FULL);
    out_data_d    = row_nxt[rd_slot_d];
    out_row_idx_d = idx_nxt[rd_slot_d];
    busy_d        = (state_nxt[0] != S_EMPTY) || (state_nxt[1] != S_EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_slot     <= 1'b0;
      rd_slot     <= 1'b0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      acc_cnt     <= '0;
      done        <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_row_idx <= '0;
      busy        <= 1'b0;
    end else begin
      wr_slot     <= wr_slot_d;
      rd_slot     <= rd_slot_d;
      col_cnt     <= col_cnt_d;
      row_cnt     <= row_cnt_d;
      acc_cnt     <= acc_cnt_d;
      done        <= done_d;
      out_valid   <= out_valid_d;
      out_data    <= out_data_d;
      out_row_idx <= out_row_idx_d;
      busy        <= busy_d;
    end
  end

`ifdef LINEAR_PROJ_OUT_OVERFLOW_EN
  // Sticky: first block arriving while both slots are full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (active && wr_full) overflow <= 1'b1;
  end
`endif

endmodule
